// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: instruction field positions,
// opcode width and the opcodes that need special handling.
package id_pkg;

  localparam int OPC_W     = 5;
  localparam int OPC_LSB   = 15;
  localparam int RD_LSB    = 10;
  localparam int RS1_LSB   = 5;
  localparam int RS2_LSB   = 0;
  localparam int IMM_W     = 10;
  localparam int IMM_ZR1_W = 15;

  localparam logic [OPC_W-1:0] OP_ZR1 = 5'b10111;
  localparam logic [OPC_W-1:0] OP_BEQ = 5'b01000;

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file, two read ports and one write port.
// Register 0 is hardwired to zero; a same-cycle write is forwarded to readers.
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Write-first reads let the consumer see writeback data in the same cycle.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = (wb_en && (wb_addr == rs1_addr)) ? wb_data : regs[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = (wb_en && (wb_addr == rs2_addr)) ? wb_data : regs[rs2_addr];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decodes fields, reads operands, resolves BEQ,
// detects load-use hazards and holds the ID/EX pipeline register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int PC_W    = 12,
  parameter int INSTR_W = 21,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_load,
  input  logic [AW-1:0]      ex_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data1,
  output logic [DATA_W-1:0]  out_data2,
  output logic [DATA_W-1:0]  out_imm,
  output logic [AW-1:0]      out_rd,
  output logic [AW-1:0]      out_rs1,
  output logic [AW-1:0]      out_rs2,
  output logic [OPC_W-1:0]   out_opcode,
  output logic               br_taken,
  output logic [PC_W-1:0]    br_target
);

  logic [OPC_W-1:0]  opcode;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [PC_W-1:0]   target;
  logic              is_zr1;
  logic              equal;
  logic              taken;
  logic              hazard;
  logic              capture;
  logic              unused_instr_bits;

  assign opcode = in_instr[OPC_LSB +: OPC_W];
  assign is_zr1 = (opcode == OP_ZR1);
  assign rd     = in_instr[RD_LSB +: AW];
  assign rs1    = is_zr1 ? '0 : in_instr[RS1_LSB +: AW];
  assign rs2    = in_instr[RS2_LSB +: AW];

  assign unused_instr_bits = ^in_instr[INSTR_W-1:OPC_LSB+OPC_W];

  // ZR1 carries a wide unsigned immediate; everything else a short signed one.
  always_comb begin
    imm = '0;
    if (is_zr1) begin
      imm[IMM_ZR1_W-1:0] = in_instr[IMM_ZR1_W-1:0];
    end else begin
      imm = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    end
  end

  regfile_bypass #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs1_addr(rs1),
    .rs2_addr(rs2),
    .rs1_data(rdata1),
    .rs2_data(rdata2)
  );

  assign equal   = (rdata1 == rdata2);
  assign taken   = (opcode == OP_BEQ) && equal;
  assign target  = in_pc + imm[PC_W-1:0];

  assign hazard   = in_valid && ex_load && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign capture  = in_valid && in_ready;

  // Flush wins over capture; an unaccepted payload simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data1  <= '0;
      out_data2  <= '0;
      out_imm    <= '0;
      out_rd     <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
      out_opcode <= '0;
      br_taken   <= 1'b0;
      br_target  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_data1  <= rdata1;
      out_data2  <= rdata2;
      out_imm    <= imm;
      out_rd     <= rd;
      out_rs1    <= rs1;
      out_rs2    <= rs2;
      out_opcode <= opcode;
      br_taken   <= taken;
      br_target  <= target;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter DATA_W, 32, register/lane data width.
REQ-002 Parameter NREGS, 16, architectural register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 Parameter PC_W, 12, program-counter width.
REQ-004 Parameter INSTR_W, 21, instruction width.
REQ-005 Port clk  in  1  single clock, all state on rising edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports in_valid in 1, in_ready out 1, in_instr in INSTR_W, in_pc in PC_W: fetch-side handshake and payload.
REQ-008 Ports wb_en in 1, wb_addr in AW, wb_data in DATA_W: writeback port.
REQ-009 Ports ex_load in 1, ex_rd in AW: EX stage holds a load writing ex_rd.
REQ-010 Port flush in 1: discard ID/EX contents.
REQ-011 Ports out_valid out 1, out_ready in 1: EX-side handshake.
REQ-012 Ports out_data1/out_data2 out DATA_W, out_imm out DATA_W, out_rd/out_rs1/out_rs2 out AW, out_opcode out 5, br_taken out 1, br_target out PC_W: registered ID/EX payload.

Function
REQ-013 SHALL decode opcode=instr[19:15], rd=instr[13:10], rs1=instr[8:5], rs2=instr[3:0] (AW LSBs of each field).
REQ-014 SHALL force rs1=0 when opcode=OP_ZR1 (5'b10111).
REQ-015 SHALL form imm = zero-extend(instr[14:0]) for OP_ZR1, else sign-extend(instr[9:0]) to DATA_W.
REQ-016 Register 0 SHALL read as 0; writes to it SHALL be ignored.
REQ-017 Reads SHALL be write-first: wb_en && wb_addr==rsX && rsX!=0 returns wb_data same cycle.
REQ-018 equal SHALL compare the two bypassed read values over full DATA_W.
REQ-019 br_taken SHALL be (opcode==OP_BEQ) && equal; br_target = in_pc + imm[PC_W-1:0], wrapping mod 2^PC_W, carry discarded.
REQ-020 hazard SHALL be in_valid && ex_load && ex_rd!=0 && (ex_rd==rs1 || ex_rd==rs2).
REQ-021 in_ready SHALL be (!out_valid || out_ready) && !hazard, combinational.
REQ-022 Capture SHALL occur when in_valid && in_ready; payload and out_valid=1 registered next edge (latency 1 cycle).
REQ-023 If out_valid && !out_ready, payload SHALL hold stable and no capture occurs.
REQ-024 If out_valid && out_ready and no capture, out_valid SHALL go 0 (bubble).
REQ-025 flush SHALL clear out_valid next edge with priority over capture; in_ready is unaffected by flush.
REQ-026 Writeback SHALL proceed every cycle regardless of stall, flush or handshake state.

Reset
REQ-027 rst_n low SHALL immediately clear out_valid, br_taken and all payload outputs to 0.
REQ-028 rst_n low SHALL clear all registers to 0; mid-transfer payload is lost.
REQ-029 First capture SHALL be possible on the first edge after rst_n deasserts.

Structure
REQ-030 Package id_pkg SHALL hold field bit positions, OP_ZR1, OP_BEQ (5'b01000) and the opcode width.
REQ-031 Sub-module regfile_bypass (NREGS x DATA_W, 2R1W, r0 hardwired, write-first bypass) SHALL hold the register file.

Verification
REQ-032 Write r3=0x0000_00AA, then BEQ r3,r3 imm=0x3FE at pc=0x005 -> br_taken=1, br_target=0x003.
REQ-033 wb_en r5=0x1234 in same cycle as instruction reading rs1=5 -> out_data1=0x1234 next cycle.
REQ-034 ex_load=1, ex_rd=2, instruction rs2=2 -> in_ready=0, no capture; ex_load drops -> capture next edge.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> payload unchanged, in_ready=0; out_ready=1 -> new capture.
REQ-036 flush and capture same edge -> out_valid=0; opcode OP_ZR1 with instr[8:5]=7 -> out_rs1=0.
REQ-037 Assert rst_n low mid-stall -> out_valid=0 immediately, r3 reads 0 afterwards.
